// File: rtl/mult8x8_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// The FSM states, step indices and datapath widths are defined here.
package mult8x8_pkg;

  localparam int OPND_W  = 8;
  localparam int PP_W    = 8;
  localparam int PROD_W  = 16;
  localparam int NIB_W   = 4;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Step order: low*low, low*high, high*low, high*high nibbles
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

endpackage

// File: rtl/mult_control.sv
// Control FSM and step counter for the sequential multiplier.
// Generates the nibble selects, shift amount and accumulator/output strobes.
module mult_control
  import mult8x8_pkg::*;
(
  input  logic               clk_i,
  input  logic               aclr_ni,
  input  logic               start_i,
  output logic               sel_a_o,
  output logic               sel_b_o,
  output logic [SHIFT_W-1:0] shift_o,
  output logic               acc_clr_o,
  output logic               acc_en_o,
  output logic               load_out_o,
  output logic               done_flag_o,
  output logic               busy_o,
  output logic [1:0]         count_o
);

  state_e     state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;

  always_ff @(posedge clk_i or negedge aclr_ni) begin
    if (!aclr_ni) begin
      state_q <= IDLE;
      count_q <= 2'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_clr_o  = 1'b0;
    acc_en_o   = 1'b0;
    load_out_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          acc_clr_o = 1'b1;
          count_d   = STEP_LL;
          state_d   = CALC;
        end
      end
      CALC: begin
        acc_en_o = 1'b1;
        count_d  = count_q + 2'd1;
        if (count_q == STEP_HH) begin
          load_out_o = 1'b1;
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = load_out_o;
    busy_d = (state_d != IDLE);
  end

  // Step index bit 1 picks the high nibble of A, bit 0 the high nibble of B
  always_comb begin
    sel_a_o = count_q[1];
    sel_b_o = count_q[0];
    case (count_q)
      STEP_LL: shift_o = SHIFT_W'(0);
      STEP_HH: shift_o = SHIFT_W'(8);
      default: shift_o = SHIFT_W'(4);
    endcase
  end

  assign done_flag_o = done_q;
  assign busy_o      = busy_q;
  assign count_o     = count_q;

endmodule

// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 partial product per cycle,
// accumulated over four steps into a registered 16-bit product.
module mult8x8_seq
  import mult8x8_pkg::*;
(
  input  logic              clk,
  input  logic              aclr_n,
  input  logic              start,
  input  logic [OPND_W-1:0] dataa,
  input  logic [OPND_W-1:0] datab,
  output logic [PROD_W-1:0] product8x8_out,
  output logic              done_flag,
  output logic              busy,
  output logic [1:0]        count_out
);

  logic               sel_a, sel_b;
  logic [SHIFT_W-1:0] shift_amt;
  logic               acc_clr, acc_en, load_out;

  logic [OPND_W-1:0]  a_q, b_q;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  product_q;
  logic [NIB_W-1:0]   nib_a, nib_b;
  logic [PP_W-1:0]    pp;
  logic [PROD_W-1:0]  pp_shifted;

  mult_control u_ctrl (
    .clk_i       (clk),
    .aclr_ni     (aclr_n),
    .start_i     (start),
    .sel_a_o     (sel_a),
    .sel_b_o     (sel_b),
    .shift_o     (shift_amt),
    .acc_clr_o   (acc_clr),
    .acc_en_o    (acc_en),
    .load_out_o  (load_out),
    .done_flag_o (done_flag),
    .busy_o      (busy),
    .count_o     (count_out)
  );

  always_comb begin
    nib_a      = sel_a ? a_q[7:4] : a_q[3:0];
    nib_b      = sel_b ? b_q[7:4] : b_q[3:0];
    pp         = PP_W'(nib_a) * PP_W'(nib_b);
    pp_shifted = PROD_W'(pp) << shift_amt;
    acc_d      = acc_q + pp_shifted;
  end

  // Operands are captured only on an accepted start, so later input changes are ignored
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else begin
      if (acc_clr) begin
        a_q   <= dataa;
        b_q   <= datab;
        acc_q <= '0;
      end else if (acc_en) begin
        acc_q <= acc_d;
      end
      if (load_out) begin
        product_q <= acc_d;
      end
    end
  end

  assign product8x8_out = product_q;

endmodule

// File: tb/tb_mult8x8_seq.sv
// Self-checking bench for mult8x8_seq: a cycle model predicts done/busy/count,
// and a queue holds expected products from accept time until the done pulse.
module tb_mult8x8_seq;

  logic        clk;
  logic        aclr_n;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product8x8_out;
  logic        done_flag;
  logic        busy;
  logic [1:0]  count_out;

  int testCount = 0;
  int failCount = 0;

  logic [15:0] sbQ[$];
  logic [15:0] lastExp = 16'h0000;
  int          modelCnt = 0;
  logic        smpStart = 1'b0;
  logic        smpRst = 1'b0;
  logic [7:0]  smpA = 8'h00;
  logic [7:0]  smpB = 8'h00;
  logic        checkEn = 1'b1;

  mult8x8_seq dut (
    .clk            (clk),
    .aclr_n         (aclr_n),
    .start          (start),
    .dataa          (dataa),
    .datab          (datab),
    .product8x8_out (product8x8_out),
    .done_flag      (done_flag),
    .busy           (busy),
    .count_out      (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Record what the DUT saw at each rising edge
  always @(posedge clk) begin
    smpStart = start;
    smpA     = dataa;
    smpB     = datab;
    smpRst   = aclr_n;
  end

  // Countdown 5..1 after an accept: 5..2 are CALC steps 0..3, 1 is DONE
  always @(negedge clk) begin
    if (checkEn) begin
      if (!aclr_n) begin
        modelCnt = 0;
        sbQ.delete();
        lastExp = 16'h0000;
      end else if (smpRst) begin
        if (modelCnt == 0) begin
          if (smpStart) begin
            sbQ.push_back(16'(smpA) * 16'(smpB));
            modelCnt = 5;
          end
        end else begin
          modelCnt--;
        end
      end
      checkOutput("done_flag", 16'(done_flag), 16'(modelCnt == 1));
      checkOutput("busy", 16'(busy), 16'(modelCnt > 0));
      checkOutput("count_out", 16'(count_out), (modelCnt >= 2) ? 16'(5 - modelCnt) : 16'h0000);
      if (done_flag) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_underflow", 16'h0001, 16'h0000);
        end else begin
          lastExp = sbQ.pop_front();
        end
      end
      checkOutput("product", product8x8_out, lastExp);
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int waitCycles);
    @(posedge clk);
    #2;
    start = 1'b1;
    dataa = a;
    datab = b;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (waitCycles) @(posedge clk);
  endtask

  initial begin
    aclr_n = 1'b0;
    start  = 1'b0;
    dataa  = 8'h00;
    datab  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    aclr_n = 1'b1;

    applyStimulus(8'hFF, 8'hFF, 7);
    applyStimulus(8'h12, 8'h34, 7);
    applyStimulus(8'h00, 8'hAB, 7);
    applyStimulus(8'h01, 8'hAB, 7);

    // Second start lands in CALC and must be ignored
    applyStimulus(8'h10, 8'h10, 1);
    applyStimulus(8'h02, 8'h03, 7);

    // Reset while step 2 is pending discards the partial result
    applyStimulus(8'hFF, 8'hFF, 2);
    #2;
    aclr_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    aclr_n = 1'b1;
    applyStimulus(8'h05, 8'h07, 7);

    // start held high with operands changing every cycle
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      start = 1'b1;
      dataa = 8'($urandom_range(0, 255));
      datab = 8'($urandom_range(0, 255));
    end
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (8) @(posedge clk);

    @(negedge clk);
    #1;
    checkEn = 1'b0;
    checkOutput("sb_drained", 16'(sbQ.size()), 16'h0000);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
